// File: rtl/fpu_ss_result_arb.sv
// Merges CSR writeback pulses and FPU results into one registered channel.
// Define FPU_SS_RESULT_PERF_EN to build the backpressure stall counter.
module fpu_ss_result_arb #(
  parameter int DEPTH    = 2,
  parameter int ID_WIDTH = 4,
  parameter int XLEN     = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                csr_wb_i,
  input  logic [4:0]          csr_wb_addr_i,
  input  logic [ID_WIDTH-1:0] csr_wb_id_i,
  input  logic [XLEN-1:0]     csr_rdata_i,
  input  logic                fpu_valid_i,
  output logic                fpu_ready_o,
  input  logic                fpu_we_i,
  input  logic [4:0]          fpu_rd_i,
  input  logic [ID_WIDTH-1:0] fpu_id_i,
  input  logic [XLEN-1:0]     fpu_data_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic                result_we_o,
  output logic [4:0]          result_rd_o,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic [XLEN-1:0]     result_data_o,
  output logic                csr_almost_full_o,
  output logic                csr_overflow_o,
  output logic [15:0]         stall_cnt_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW-1:0] HIGH = CW'(DEPTH - 1);

  logic [4:0]          fifo_addr [DEPTH];
  logic [ID_WIDTH-1:0] fifo_id   [DEPTH];
  logic [XLEN-1:0]     fifo_data [DEPTH];

  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic          empty;
  logic          load;
  logic          pop;
  logic          push;

  assign empty = (count == '0);
  assign load  = !result_valid_o || result_ready_i;
  assign pop   = load && !empty;
  // A pop in the same cycle frees a slot even when full.
  assign push  = csr_wb_i && ((count < FULL) || pop);

  assign fpu_ready_o       = load && empty;
  assign csr_almost_full_o = (count >= HIGH);

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_addr[wptr] <= csr_wb_addr_i;
      fifo_id[wptr]   <= csr_wb_id_i;
      fifo_data[wptr] <= csr_rdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr           <= '0;
      rptr           <= '0;
      count          <= '0;
      csr_overflow_o <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (csr_wb_i && !push) csr_overflow_o <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      result_valid_o <= 1'b0;
      result_we_o    <= 1'b0;
      result_rd_o    <= '0;
      result_id_o    <= '0;
      result_data_o  <= '0;
    end else if (load) begin
      if (pop) begin
        result_valid_o <= 1'b1;
        result_we_o    <= 1'b1;
        result_rd_o    <= fifo_addr[rptr];
        result_id_o    <= fifo_id[rptr];
        result_data_o  <= fifo_data[rptr];
      end else if (fpu_valid_i) begin
        result_valid_o <= 1'b1;
        result_we_o    <= fpu_we_i;
        result_rd_o    <= fpu_rd_i;
        result_id_o    <= fpu_id_i;
        result_data_o  <= fpu_data_i;
      end else begin
        result_valid_o <= 1'b0;
      end
    end
  end

`ifdef FPU_SS_RESULT_PERF_EN
  logic [15:0] stall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt <= '0;
    end else if (result_valid_o && !result_ready_i
                 && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_fpu_ss_result_arb.sv
// Self-checking bench for fpu_ss_result_arb: cycle table plus scoreboard.
// Hand-written sequences cover hold/stall and reset mid-transfer.
module tb_fpu_ss_result_arb;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        csr_wb_i;
  logic [4:0]  csr_wb_addr_i;
  logic [3:0]  csr_wb_id_i;
  logic [31:0] csr_rdata_i;
  logic        fpu_valid_i;
  logic        fpu_ready_o;
  logic        fpu_we_i;
  logic [4:0]  fpu_rd_i;
  logic [3:0]  fpu_id_i;
  logic [31:0] fpu_data_i;
  logic        result_valid_o;
  logic        result_ready_i;
  logic        result_we_o;
  logic [4:0]  result_rd_o;
  logic [3:0]  result_id_o;
  logic [31:0] result_data_o;
  logic        csr_almost_full_o;
  logic        csr_overflow_o;
  logic [15:0] stall_cnt_o;

  always #5 clk = ~clk;

  fpu_ss_result_arb #(
    .DEPTH(2), .ID_WIDTH(4), .XLEN(32)
  ) dut (
    .clk_i(clk),
    .rst_i(rst_i),
    .csr_wb_i(csr_wb_i),
    .csr_wb_addr_i(csr_wb_addr_i),
    .csr_wb_id_i(csr_wb_id_i),
    .csr_rdata_i(csr_rdata_i),
    .fpu_valid_i(fpu_valid_i),
    .fpu_ready_o(fpu_ready_o),
    .fpu_we_i(fpu_we_i),
    .fpu_rd_i(fpu_rd_i),
    .fpu_id_i(fpu_id_i),
    .fpu_data_i(fpu_data_i),
    .result_valid_o(result_valid_o),
    .result_ready_i(result_ready_i),
    .result_we_o(result_we_o),
    .result_rd_o(result_rd_o),
    .result_id_o(result_id_o),
    .result_data_o(result_data_o),
    .csr_almost_full_o(csr_almost_full_o),
    .csr_overflow_o(csr_overflow_o),
    .stall_cnt_o(stall_cnt_o)
  );

  typedef struct {
    logic        csr;
    logic [4:0]  addr;
    logic [3:0]  cid;
    logic [31:0] rdata;
    logic        drop;
    logic        fv;
    logic        fwe;
    logic [4:0]  rd;
    logic [3:0]  fid;
    logic [31:0] fdata;
    logic        rdy;
    logic        ev;
    logic        efr;
    logic        eaf;
    logic        eovf;
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [3:0]  id;
    logic [31:0] data;
  } beat_t;

  vec_t  tbl[22];
  beat_t sb[$];
  int    checks = 0;
  int    fails  = 0;

  function automatic vec_t x(bit rdy, bit ev, bit efr, bit eaf, bit eovf);
    vec_t v;
    v.csr = 0; v.addr = '0; v.cid = '0; v.rdata = '0; v.drop = 0;
    v.fv = 0; v.fwe = 0; v.rd = '0; v.fid = '0; v.fdata = '0;
    v.rdy = rdy; v.ev = ev; v.efr = efr; v.eaf = eaf; v.eovf = eovf;
    return v;
  endfunction

  function automatic vec_t c(vec_t v, logic [4:0] a, logic [3:0] i,
                             logic [31:0] d, bit drop);
    v.csr = 1; v.addr = a; v.cid = i; v.rdata = d; v.drop = drop;
    return v;
  endfunction

  function automatic vec_t f(vec_t v, bit we, logic [4:0] r,
                             logic [3:0] i, logic [31:0] d);
    v.fv = 1; v.fwe = we; v.rd = r; v.fid = i; v.fdata = d;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(vec_t v, string tag);
    beat_t b;
    @(posedge clk); #1;
    csr_wb_i       = v.csr;
    csr_wb_addr_i  = v.addr;
    csr_wb_id_i    = v.cid;
    csr_rdata_i    = v.rdata;
    fpu_valid_i    = v.fv;
    fpu_we_i       = v.fwe;
    fpu_rd_i       = v.rd;
    fpu_id_i       = v.fid;
    fpu_data_i     = v.fdata;
    result_ready_i = v.rdy;
    @(negedge clk);
    chk({tag, " valid"}, 32'(result_valid_o), 32'(v.ev));
    chk({tag, " fpu_ready"}, 32'(fpu_ready_o), 32'(v.efr));
    chk({tag, " almost_full"}, 32'(csr_almost_full_o), 32'(v.eaf));
    chk({tag, " overflow"}, 32'(csr_overflow_o), 32'(v.eovf));
    if (result_valid_o && result_ready_i) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL %s beat: got id %h expected no beat", tag, result_id_o);
      end else begin
        b = sb.pop_front();
        chk({tag, " we"}, 32'(result_we_o), 32'(b.we));
        chk({tag, " rd"}, 32'(result_rd_o), 32'(b.rd));
        chk({tag, " id"}, 32'(result_id_o), 32'(b.id));
        chk({tag, " data"}, result_data_o, b.data);
      end
    end
    if (v.fv && v.efr) begin
      b.we = v.fwe; b.rd = v.rd; b.id = v.fid; b.data = v.fdata;
      sb.push_back(b);
    end
    if (v.csr && !v.drop) begin
      b.we = 1'b1; b.rd = v.addr; b.id = v.cid; b.data = v.rdata;
      sb.push_back(b);
    end
  endtask

  task automatic run(int lo, int hi);
    for (int i = lo; i <= hi; i++) step(tbl[i], $sformatf("row%0d", i));
  endtask

  task automatic do_reset(string tag);
    @(posedge clk); #1;
    rst_i          = 1'b1;
    csr_wb_i       = 1'b0;
    fpu_valid_i    = 1'b0;
    result_ready_i = 1'b0;
    @(posedge clk); #1;
    rst_i = 1'b0;
    sb.delete();
    @(negedge clk);
    chk({tag, " valid"}, 32'(result_valid_o), 0);
    chk({tag, " we"}, 32'(result_we_o), 0);
    chk({tag, " data"}, result_data_o, 0);
    chk({tag, " almost_full"}, 32'(csr_almost_full_o), 0);
    chk({tag, " overflow"}, 32'(csr_overflow_o), 0);
    chk({tag, " stall_cnt"}, 32'(stall_cnt_o), 0);
    chk({tag, " fpu_ready"}, 32'(fpu_ready_o), 1);
  endtask

  initial begin
    rst_i = 1'b1;
    csr_wb_i = 0; csr_wb_addr_i = '0; csr_wb_id_i = '0; csr_rdata_i = '0;
    fpu_valid_i = 0; fpu_we_i = 0; fpu_rd_i = '0; fpu_id_i = '0;
    fpu_data_i = '0; result_ready_i = 0;

    tbl[0]  = f(x(1, 0, 1, 0, 0), 1, 5, 3, 32'h3F80_0000);
    tbl[1]  = x(1, 1, 1, 0, 0);
    tbl[2]  = x(1, 0, 1, 0, 0);
    tbl[3]  = c(x(1, 0, 1, 0, 0), 10, 7, 32'h0000_0060, 0);
    tbl[4]  = x(1, 0, 0, 1, 0);
    tbl[5]  = x(1, 1, 1, 0, 0);
    tbl[6]  = x(1, 0, 1, 0, 0);
    tbl[7]  = f(x(1, 0, 1, 0, 0), 0, 1, 9, 32'hDEAD_BEEF);
    tbl[8]  = x(1, 1, 1, 0, 0);
    tbl[9]  = c(f(x(1, 0, 1, 0, 0), 1, 4, 1, 32'h22), 3, 2, 32'h11, 0);
    tbl[10] = x(1, 1, 0, 1, 0);
    tbl[11] = x(1, 1, 1, 0, 0);
    tbl[12] = x(1, 0, 1, 0, 0);
    tbl[13] = c(x(0, 0, 1, 0, 0), 1, 1, 32'h101, 0);
    tbl[14] = c(x(0, 0, 0, 1, 0), 2, 2, 32'h202, 0);
    tbl[15] = c(x(0, 1, 0, 1, 0), 3, 3, 32'h303, 0);
    tbl[16] = c(x(0, 1, 0, 1, 0), 4, 4, 32'h404, 1);
    tbl[17] = x(0, 1, 0, 1, 1);
    tbl[18] = x(1, 1, 0, 1, 1);
    tbl[19] = x(1, 1, 0, 1, 1);
    tbl[20] = x(1, 1, 1, 0, 1);
    tbl[21] = x(1, 0, 1, 0, 1);

    do_reset("reset");
    run(0, 21);

    // Hold a result for five stalled cycles, then release it.
    do_reset("reset2");
    step(f(x(0, 0, 1, 0, 0), 1, 6, 5, 32'h1234_5678), "hold0");
    for (int i = 1; i <= 5; i++) begin
      step(x(0, 1, 0, 0, 0), $sformatf("hold%0d", i));
      chk($sformatf("hold%0d rd", i), 32'(result_rd_o), 6);
      chk($sformatf("hold%0d id", i), 32'(result_id_o), 5);
      chk($sformatf("hold%0d data", i), result_data_o, 32'h1234_5678);
    end
    step(x(1, 1, 1, 0, 0), "hold6");
`ifdef FPU_SS_RESULT_PERF_EN
    chk("stall_cnt", 32'(stall_cnt_o), 5);
`else
    chk("stall_cnt", 32'(stall_cnt_o), 0);
`endif
    step(x(1, 0, 1, 0, 0), "hold7");

    // Fill FIFO plus output register, overflow, then reset mid-transfer.
    run(13, 17);
    do_reset("midreset");
    run(0, 2);

    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending beats expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
